// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames one word per request (start, LSB-first data,
// optional parity, 1-2 stop bits) and paces each bit from an external baud counter.
module uart_tx_ctrl #(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic        tx_start,
    input  logic [7:0]  tx_data,
    input  logic [19:0] baud_cnt,
    output logic        baud_cnt_rst,
    output logic        baud_cnt_en,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [19:0] BIT_LAST  = 20'(BAUD_DIV - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);
    localparam logic        ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_shreg, w_shreg_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_stop, w_stop_nxt;
    logic        r_parity, w_parity_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_done, w_done_nxt;
    logic        w_bit_end;

    // >= so an overshooting (or decoupled) count still closes the bit.
    assign w_bit_end = (r_state != S_IDLE) && (baud_cnt >= BIT_LAST);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_idx    <= '0;
            r_stop   <= 1'b0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_idx    <= w_idx_nxt;
            r_stop   <= w_stop_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_idx_nxt    = r_idx;
        w_stop_nxt   = r_stop;
        w_parity_nxt = r_parity;
        w_tx_nxt     = r_tx;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_state_nxt  = S_START;
                    w_shreg_nxt  = tx_data;
                    w_parity_nxt = (^(tx_data & DATA_MASK)) ^ ODD;
                    w_idx_nxt    = '0;
                    w_stop_nxt   = 1'b0;
                    w_tx_nxt     = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shreg[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx < IDX_LAST) begin
                        w_shreg_nxt = r_shreg >> 1;
                        w_idx_nxt   = r_idx + 3'd1;
                        w_tx_nxt    = r_shreg[1];
                    end else if (PARITY_EN != 0) begin
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_parity;
                    end else begin
                        w_state_nxt = S_STOP;
                        w_stop_nxt  = 1'b0;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_stop_nxt  = 1'b0;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stop == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Counter is held at 0 while idle and restarted at every bit boundary.
    assign baud_cnt_rst = (r_state == S_IDLE) || w_bit_end;
    assign baud_cnt_en  = (r_state != S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign tx           = r_tx;
    assign done         = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four configurations side by side, each with a behavioural
// baud counter, checked cycle-by-cycle against a bit-list model of the frame.
module tb_uart_tx_ctrl;

    localparam int NU = 4;
    localparam int BD = 4;
    localparam int DB [NU] = '{8, 8, 8, 7};
    localparam int PE [NU] = '{0, 1, 1, 1};
    localparam int PO [NU] = '{0, 0, 1, 0};
    localparam int SB [NU] = '{1, 1, 1, 2};

    logic        clk = 1'b0;
    logic        rst_async;
    logic        tx_start [NU];
    logic [7:0]  tx_data  [NU];
    logic [19:0] bc       [NU];
    logic [19:0] cnt      [NU];
    logic        cr       [NU];
    logic        ce       [NU];
    logic        tx       [NU];
    logic        busy     [NU];
    logic        done     [NU];
    logic        force_en;
    logic [19:0] force_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NU; i++) begin : g_dut
        uart_tx_ctrl #(
            .BAUD_DIV  (BD),
            .DATA_BITS (DB[i]),
            .PARITY_EN (PE[i]),
            .PARITY_ODD(PO[i]),
            .STOP_BITS (SB[i])
        ) u_dut (
            .clk         (clk),
            .rst_async   (rst_async),
            .tx_start    (tx_start[i]),
            .tx_data     (tx_data[i]),
            .baud_cnt    (bc[i]),
            .baud_cnt_rst(cr[i]),
            .baud_cnt_en (ce[i]),
            .tx          (tx[i]),
            .busy        (busy[i]),
            .done        (done[i])
        );
    end

    // Baud counter: synchronous clear has priority over enable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if (cr[i])      cnt[i] <= '0;
            else if (ce[i]) cnt[i] <= cnt[i] + 20'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NU; i++) bc[i] = cnt[i];
        if (force_en) bc[1] = force_val;
    end

    task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s u%0d t=%0t observed=%0h expected=%0h", tag, u, $time, obs, exp);
        end
    endtask

    // Expected line levels, one entry per bit period.
    task automatic build_frame(input int u, input logic [7:0] d, output bit q[$]);
        int ones;
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < DB[u]; i++) q.push_back(d[i]);
        if (PE[u] != 0) begin
            ones = 0;
            for (int i = 0; i < DB[u]; i++) ones += int'(d[i]);
            q.push_back(bit'((ones % 2) ^ PO[u]));
        end
        for (int i = 0; i < SB[u]; i++) q.push_back(1'b1);
    endtask

    task automatic run_bits(input int u, input bit q[$], input int first, input int last, input int ign_at);
        int cyc = 0;
        for (int b = first; b <= last; b++) begin
            for (int c = 0; c < BD; c++) begin
                chk("tx", u, 32'(tx[u]), 32'(q[b]));
                chk("busy", u, 32'(busy[u]), 1);
                chk("done_low", u, 32'(done[u]), 0);
                chk("cnt", u, 32'(bc[u]), 32'(c));
                chk("cnt_rst", u, 32'(cr[u]), 32'(c == BD - 1));
                chk("cnt_en", u, 32'(ce[u]), 1);
                if (ign_at >= 0) begin
                    if (cyc == ign_at) begin
                        tx_start[u] = 1'b1;
                        tx_data[u]  = 8'h00;
                    end else if (cyc == ign_at + 1) begin
                        tx_start[u] = 1'b0;
                    end
                end
                cyc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_end(input int u);
        chk("done_pulse", u, 32'(done[u]), 1);
        chk("busy_end", u, 32'(busy[u]), 0);
        chk("tx_end", u, 32'(tx[u]), 1);
        chk("cnt_rst_idle", u, 32'(cr[u]), 1);
        chk("cnt_en_idle", u, 32'(ce[u]), 0);
        @(negedge clk);
    endtask

    task automatic idle_check(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_tx", u, 32'(tx[u]), 1);
            chk("idle_busy", u, 32'(busy[u]), 0);
            chk("idle_done", u, 32'(done[u]), 0);
            @(negedge clk);
        end
    endtask

    task automatic accept(input int u, input logic [7:0] d);
        tx_start[u] = 1'b1;
        tx_data[u]  = d;
        @(negedge clk);
        tx_start[u] = 1'b0;
        tx_data[u]  = 8'($urandom);
    endtask

    task automatic send(input int u, input logic [7:0] d, input int ign_at);
        bit q[$];
        build_frame(u, d, q);
        accept(u, d);
        run_bits(u, q, 0, q.size() - 1, ign_at);
        check_end(u);
    endtask

    initial begin
        bit q[$];
        bit q2[$];
        logic [7:0] d;
        int u;
        rst_async = 1'b1;
        force_en  = 1'b0;
        force_val = 20'd10;
        for (int i = 0; i < NU; i++) begin
            tx_start[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NU; i++) begin
            chk("rst_tx", i, 32'(tx[i]), 1);
            chk("rst_busy", i, 32'(busy[i]), 0);
            chk("rst_done", i, 32'(done[i]), 0);
            chk("rst_cnt_rst", i, 32'(cr[i]), 1);
            chk("rst_cnt_en", i, 32'(ce[i]), 0);
            chk("rst_cnt", i, 32'(bc[i]), 0);
        end
        rst_async = 1'b0;
        @(negedge clk);

        // Directed frames from the plan.
        send(0, 8'hA5, -1);
        idle_check(0, 2);
        send(1, 8'hA5, -1);
        send(1, 8'h01, -1);
        send(2, 8'h01, -1);
        send(3, 8'hFF, 10);
        idle_check(3, 12);

        // Back-to-back with tx_start held.
        build_frame(0, 8'h3C, q);
        tx_start[0] = 1'b1;
        tx_data[0]  = 8'h3C;
        @(negedge clk);
        run_bits(0, q, 0, q.size() - 1, -1);
        check_end(0);
        tx_start[0] = 1'b0;
        tx_data[0]  = 8'($urandom);
        run_bits(0, q, 0, q.size() - 1, -1);
        check_end(0);
        idle_check(0, 2);

        // Reset during data bit 3, with tx_start asserted alongside it.
        d = 8'($urandom);
        build_frame(0, d, q);
        accept(0, d);
        run_bits(0, q, 0, 3, -1);
        repeat (2) @(negedge clk);
        rst_async   = 1'b1;
        tx_start[0] = 1'b1;
        tx_data[0]  = 8'h55;
        #1;
        chk("midrst_tx", 0, 32'(tx[0]), 1);
        chk("midrst_busy", 0, 32'(busy[0]), 0);
        chk("midrst_cnt_rst", 0, 32'(cr[0]), 1);
        @(negedge clk);
        chk("midrst_cnt", 0, 32'(bc[0]), 0);
        chk("midrst_start_ignored", 0, 32'(busy[0]), 0);
        rst_async   = 1'b0;
        tx_start[0] = 1'b0;
        idle_check(0, 2);
        chk("post_rst_cnt", 0, 32'(bc[0]), 0);
        send(0, 8'h55, -1);

        // Decoupled count overshoot in data bit 2.
        d = 8'($urandom);
        build_frame(1, d, q2);
        accept(1, d);
        run_bits(1, q2, 0, 2, -1);
        @(negedge clk);
        force_en = 1'b1;
        #1;
        chk("force_cnt_rst", 1, 32'(cr[1]), 1);
        chk("force_tx_before", 1, 32'(tx[1]), 32'(q2[3]));
        @(negedge clk);
        force_en = 1'b0;
        #1;
        chk("force_tx_after", 1, 32'(tx[1]), 32'(q2[4]));
        run_bits(1, q2, 4, q2.size() - 1, -1);
        check_end(1);

        // Random frames across all configurations.
        for (int n = 0; n < 16; n++) begin
            u = int'($urandom_range(0, NU - 1));
            send(u, 8'($urandom), -1);
            idle_check(u, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
